// File: rtl/motor_duty_ramp_pkg.sv
// Shared widths, neutral duty, ramp FSM states and the speed-to-duty map
// for the H-bridge duty ramp.
package mtr_pkg;
    localparam int DUTY_W = 11;
    localparam int SPD_W  = 12;

    localparam logic [DUTY_W-1:0] DUTY_NEUTRAL = 11'h400;
    localparam logic [DUTY_W-1:0] CNT_PRE_LAST = 11'h7FE;

    typedef enum logic [1:0] {IDLE, RUN, STOP} ramp_state_t;

    // Halved signed speed centred on neutral: -2048 -> 0x000, 2047 -> 0x7FF.
    function automatic logic [DUTY_W-1:0] spd_to_duty(input logic signed [SPD_W-1:0] spd);
        logic signed [SPD_W-1:0] sum;
        sum = $signed({1'b0, DUTY_NEUTRAL}) + (spd >>> 1);
        return sum[DUTY_W-1:0];
    endfunction
endpackage

// File: rtl/motor_duty_ramp_if.sv
// Command/status bundle between the motion controller and the duty ramp.
interface motor_duty_ramp_if;
    import mtr_pkg::*;

    logic              en;
    logic              cmd_vld;
    logic [SPD_W-1:0]  lft_spd;
    logic [SPD_W-1:0]  rght_spd;
    logic [DUTY_W-1:0] lft_duty;
    logic [DUTY_W-1:0] rght_duty;
    logic              period_tick;
    logic              at_tgt;
    logic              idle;

    modport master (
        output en, cmd_vld, lft_spd, rght_spd,
        input  lft_duty, rght_duty, period_tick, at_tgt, idle
    );

    modport slave (
        input  en, cmd_vld, lft_spd, rght_spd,
        output lft_duty, rght_duty, period_tick, at_tgt, idle
    );
endinterface

// File: rtl/motor_duty_ramp_duty_slew.sv
// One duty channel: holds the duty and moves it toward eff_tgt by at most
// RAMP_STEP on each period tick, landing exactly on the target.
module duty_slew
    import mtr_pkg::*;
#(
    parameter int RAMP_STEP = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic [DUTY_W-1:0] eff_tgt,
    output logic [DUTY_W-1:0] duty,
    output logic [DUTY_W-1:0] duty_next
);
    localparam logic signed [DUTY_W:0] STEP_S = (DUTY_W+1)'(RAMP_STEP);

    logic [DUTY_W-1:0]       duty_q;
    logic [DUTY_W-1:0]       duty_d;
    logic signed [DUTY_W:0]  diff;

    // A full step is taken only when the target is further away than a step,
    // so the result always stays between duty and target and cannot wrap.
    always_comb begin
        diff   = $signed({1'b0, eff_tgt}) - $signed({1'b0, duty_q});
        duty_d = duty_q;
        if (tick) begin
            if (diff > STEP_S) begin
                duty_d = duty_q + STEP_S[DUTY_W-1:0];
            end else if (diff < -STEP_S) begin
                duty_d = duty_q - STEP_S[DUTY_W-1:0];
            end else begin
                duty_d = eff_tgt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= DUTY_NEUTRAL;
        end else begin
            duty_q <= duty_d;
        end
    end

    assign duty      = duty_q;
    assign duty_next = duty_d;
endmodule

// File: rtl/motor_duty_ramp.sv
// Left/right duty feeder for the PWM blocks: target latching, period counter,
// IDLE/RUN/STOP sequencing and two slew-limited duty channels.
module motor_duty_ramp
    import mtr_pkg::*;
#(
    parameter int RAMP_STEP = 8
) (
    input logic               clk,
    input logic               rst_n,
    motor_duty_ramp_if.slave  bus
);
    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic              tick_q, tick_d;
    logic [DUTY_W-1:0] tgt_l_q, tgt_l_d;
    logic [DUTY_W-1:0] tgt_r_q, tgt_r_d;
    ramp_state_t       state_q, state_d;

    logic [DUTY_W-1:0] eff_l, eff_r;
    logic [DUTY_W-1:0] duty_l, duty_r;
    logic [DUTY_W-1:0] nxt_l, nxt_r;

    // Tick is registered from the count one before the last, so it is high
    // exactly while cnt==7FF and the duty loads as the PWM period rolls over.
    always_comb begin
        cnt_d   = cnt_q + DUTY_W'(1);
        tick_d  = (cnt_q == CNT_PRE_LAST);
        tgt_l_d = bus.cmd_vld ? spd_to_duty(bus.lft_spd)  : tgt_l_q;
        tgt_r_d = bus.cmd_vld ? spd_to_duty(bus.rght_spd) : tgt_r_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.en) state_d = RUN;
            RUN:  if (!bus.en) state_d = STOP;
            STOP: begin
                if (bus.en) begin
                    state_d = RUN;
                end else if (tick_q && nxt_l == DUTY_NEUTRAL && nxt_r == DUTY_NEUTRAL) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            tgt_l_q <= DUTY_NEUTRAL;
            tgt_r_q <= DUTY_NEUTRAL;
            state_q <= IDLE;
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            tgt_l_q <= tgt_l_d;
            tgt_r_q <= tgt_r_d;
            state_q <= state_d;
        end
    end

    assign eff_l = (state_q == RUN) ? tgt_l_q : DUTY_NEUTRAL;
    assign eff_r = (state_q == RUN) ? tgt_r_q : DUTY_NEUTRAL;

    duty_slew #(.RAMP_STEP(RAMP_STEP)) u_slew_l (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick_q),
        .eff_tgt   (eff_l),
        .duty      (duty_l),
        .duty_next (nxt_l)
    );

    duty_slew #(.RAMP_STEP(RAMP_STEP)) u_slew_r (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick_q),
        .eff_tgt   (eff_r),
        .duty      (duty_r),
        .duty_next (nxt_r)
    );

    assign bus.lft_duty    = duty_l;
    assign bus.rght_duty   = duty_r;
    assign bus.period_tick = tick_q;
    assign bus.at_tgt      = (duty_l == eff_l) && (duty_r == eff_r);
    assign bus.idle        = (state_q == IDLE);
endmodule

// File: tb/tb_motor_duty_ramp.sv
// Bench for motor_duty_ramp: period-level reference model checked every cycle,
// directed ramp scenarios with literal checkpoints, and a large-step copy for clamping.
module tb_motor_duty_ramp;
    localparam int STEP      = 8;
    localparam int FAST_STEP = 256;
    localparam int PERIOD    = 2048;
    localparam int NEUTRAL   = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    motor_duty_ramp_if bus ();
    motor_duty_ramp_if fbus ();

    assign fbus.en       = bus.en;
    assign fbus.cmd_vld  = bus.cmd_vld;
    assign fbus.lft_spd  = bus.lft_spd;
    assign fbus.rght_spd = bus.rght_spd;

    motor_duty_ramp #(.RAMP_STEP(STEP)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    motor_duty_ramp #(.RAMP_STEP(FAST_STEP)) u_fast (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fbus.slave)
    );

    int n_checks = 0;
    int n_err    = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        chk(nm, act, exp);
        $display("check %-14s got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: counts clocks since reset, applies one slew step per
    // period end, and follows the enable/neutral rules to pick the target.
    int m_n = 0, m_l = NEUTRAL, m_r = NEUTRAL, m_tl = NEUTRAL, m_tr = NEUTRAL;
    int m_mode = 0;  // 0 idle, 1 run, 2 stop

    function automatic int approach(input int cur, input int tgt);
        if (tgt > cur + STEP) return cur + STEP;
        if (tgt < cur - STEP) return cur - STEP;
        return tgt;
    endfunction

    function automatic int spd_map(input logic [11:0] s);
        int v;
        v = int'($signed(s));
        return NEUTRAL + (v >>> 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit was_tick;
        if (!rst_n) begin
            m_n = 0; m_l = NEUTRAL; m_r = NEUTRAL;
            m_tl = NEUTRAL; m_tr = NEUTRAL; m_mode = 0;
        end else begin
            was_tick = (m_n % PERIOD) == PERIOD - 1;
            if (was_tick) begin
                m_l = approach(m_l, (m_mode == 1) ? m_tl : NEUTRAL);
                m_r = approach(m_r, (m_mode == 1) ? m_tr : NEUTRAL);
            end
            if (bus.cmd_vld) begin
                m_tl = spd_map(bus.lft_spd);
                m_tr = spd_map(bus.rght_spd);
            end
            case (m_mode)
                0: if (bus.en) m_mode = 1;
                1: if (!bus.en) m_mode = 2;
                default: begin
                    if (bus.en) m_mode = 1;
                    else if (was_tick && m_l == NEUTRAL && m_r == NEUTRAL) m_mode = 0;
                end
            endcase
            m_n++;
        end
    end

    always @(posedge clk) begin
        int el, er;
        #1;
        if (chk_on && rst_n) begin
            el = (m_mode == 1) ? m_tl : NEUTRAL;
            er = (m_mode == 1) ? m_tr : NEUTRAL;
            chk("lft_duty",    int'(bus.lft_duty),    m_l);
            chk("rght_duty",   int'(bus.rght_duty),   m_r);
            chk("period_tick", int'(bus.period_tick), int'((m_n % PERIOD) == PERIOD - 1));
            chk("at_tgt",      int'(bus.at_tgt),      int'(m_l == el && m_r == er));
            chk("idle",        int'(bus.idle),        int'(m_mode == 0));
        end
    end

    // Returns on the falling edge after the n-th tick, i.e. with new duties visible.
    task automatic wait_ticks(input int n, output int cycles);
        int seen = 0;
        int budget = n * PERIOD + 16;
        cycles = 0;
        while (seen < n && budget > 0) begin
            @(negedge clk);
            budget--;
            cycles++;
            if (bus.period_tick) seen++;
        end
        chk("tick_wait", seen, n);
        @(negedge clk);
    endtask

    task automatic wait_tick_cycle();
        int budget = PERIOD + 16;
        do begin
            @(negedge clk);
            budget--;
        end while (!bus.period_tick && budget > 0);
        chk("tick_found", int'(bus.period_tick), 1);
    endtask

    task automatic send_cmd(input logic [11:0] l, input logic [11:0] r);
        bus.lft_spd  = l;
        bus.rght_spd = r;
        bus.cmd_vld  = 1'b1;
        @(negedge clk);
        bus.cmd_vld  = 1'b0;
    endtask

    initial begin
        int cyc;
        bus.en = 1'b0;
        bus.cmd_vld = 1'b0;
        bus.lft_spd = '0;
        bus.rght_spd = '0;

        repeat (3) @(negedge clk);
        lit("rst_lft",    int'(bus.lft_duty),    'h400);
        lit("rst_rght",   int'(bus.rght_duty),   'h400);
        lit("rst_idle",   int'(bus.idle),        1);
        lit("rst_at_tgt", int'(bus.at_tgt),      1);
        lit("rst_tick",   int'(bus.period_tick), 0);
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // Disabled for three periods: neutral, idle, tick every 2048 clocks.
        wait_ticks(3, cyc);
        lit("third_tick_at", cyc, 3 * PERIOD - 1);
        lit("a_lft",  int'(bus.lft_duty), 'h400);
        lit("a_idle", int'(bus.idle), 1);

        // Full-scale command: +8 / -8 per period; fast copy clamps at the rails.
        bus.en = 1'b1;
        send_cmd(12'sd2047, -12'sd2048);
        wait_ticks(3, cyc);
        lit("b_lft3",   int'(bus.lft_duty),   'h418);
        lit("b_rght3",  int'(bus.rght_duty),  'h3E8);
        lit("f_lft3",   int'(fbus.lft_duty),  'h700);
        lit("f_rght3",  int'(fbus.rght_duty), 'h100);
        wait_ticks(5, cyc);
        lit("b_lft8",   int'(bus.lft_duty),   'h440);
        lit("b_rght8",  int'(bus.rght_duty),  'h3C0);
        lit("f_lft_max",  int'(fbus.lft_duty),  'h7FF);
        lit("f_rght_min", int'(fbus.rght_duty), 'h000);
        lit("f_at_tgt",   int'(fbus.at_tgt),    1);

        // Disable: ramp back toward neutral.
        bus.en = 1'b0;
        wait_ticks(4, cyc);
        lit("c_lft",  int'(bus.lft_duty),  'h420);
        lit("c_rght", int'(bus.rght_duty), 'h3E0);
        lit("c_idle", int'(bus.idle), 0);

        // Re-enable from STOP: resumes from current duty toward new targets.
        bus.en = 1'b1;
        send_cmd(12'sd96, -12'sd16);
        wait_ticks(1, cyc);
        lit("d_lft1", int'(bus.lft_duty),  'h428);
        lit("d_rght1", int'(bus.rght_duty), 'h3E8);
        wait_ticks(2, cyc);
        lit("d_lft3",  int'(bus.lft_duty),  'h430);
        lit("d_rght3", int'(bus.rght_duty), 'h3F8);
        lit("d_at_tgt", int'(bus.at_tgt), 1);

        // Stop to idle: IDLE only on the tick where both reach neutral.
        bus.en = 1'b0;
        wait_ticks(5, cyc);
        lit("e_lft5",  int'(bus.lft_duty), 'h408);
        lit("e_idle5", int'(bus.idle), 0);
        wait_ticks(1, cyc);
        lit("e_lft6",  int'(bus.lft_duty),  'h400);
        lit("e_rght6", int'(bus.rght_duty), 'h400);
        lit("e_idle6", int'(bus.idle), 1);

        // Strobe on the tick cycle: the tick still uses the old target.
        bus.en = 1'b1;
        send_cmd(12'sd8, 12'sd8);
        wait_tick_cycle();
        send_cmd(12'sd2047, 12'sd2047);
        lit("f_tick1", int'(bus.lft_duty), 'h404);
        wait_ticks(1, cyc);
        lit("f_tick2", int'(bus.lft_duty), 'h40C);

        // Asynchronous reset mid-ramp.
        repeat (500) @(negedge clk);
        rst_n = 1'b0;
        #1;
        lit("g_lft",  int'(bus.lft_duty),  'h400);
        lit("g_rght", int'(bus.rght_duty), 'h400);
        lit("g_idle", int'(bus.idle), 1);
        lit("g_cnt",  int'(u_dut.cnt_q), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        lit("g_at_tgt", int'(bus.at_tgt), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
